// File: rtl/sine_phase_decoder.sv
// sine_phase_decoder
//   Recovers the 8-bit DDS phase (256 steps/period) that produced a signed
//   10-bit sine sample plus a slope flag. A 6-step MSB-first binary search
//   over a 64-entry quarter-wave magnitude ROM finds the largest k with
//   ROM[k] <= |sample|. It does one ROM read per cycle. The quadrant is then
//   folded back into the phase.
//   One request takes 8 cycles: IDLE (accept), 6 x SEARCH, DONE.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request, sampled only while idle
//   sample     in   [9:0] two's-complement sine sample, captured on accept
//   slope      in   1 = rising part of waveform, 0 = falling; captured on accept
//   busy       out  high while searching and in the done cycle
//   done       out  one-cycle pulse, phase_out valid from this cycle onward
//   phase_out  out  [7:0] decoded phase, held until the next done
//   residual   out  [3:0] mag - ROM[k], only with SINE_PHASE_RESIDUAL_EN
//
// Build option
//   SINE_PHASE_RESIDUAL_EN : adds the residual output and its logic.
module sine_phase_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] sample,
  input  logic       slope,
  output logic       busy,
  output logic       done,
  output logic [7:0] phase_out
`ifdef SINE_PHASE_RESIDUAL_EN
  ,
  output logic [3:0] residual
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0] state_q, state_d;
  logic [8:0] mag_q, mag_d;
  logic       sign_q, sign_d;
  logic       slope_q, slope_d;
  logic [5:0] k_q, k_d;
  logic [2:0] bit_q, bit_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] phase_q, phase_d;

  // floor(512*sin(pi*k/128)), k = 0..63
  function automatic logic [8:0] rom_lookup(input logic [5:0] a);
    logic [8:0] r;
    case (a)
      6'd0:  r = 9'd0;   6'd1:  r = 9'd12;  6'd2:  r = 9'd25;  6'd3:  r = 9'd37;
      6'd4:  r = 9'd50;  6'd5:  r = 9'd62;  6'd6:  r = 9'd75;  6'd7:  r = 9'd87;
      6'd8:  r = 9'd99;  6'd9:  r = 9'd112; 6'd10: r = 9'd124; 6'd11: r = 9'd136;
      6'd12: r = 9'd148; 6'd13: r = 9'd160; 6'd14: r = 9'd172; 6'd15: r = 9'd184;
      6'd16: r = 9'd195; 6'd17: r = 9'd207; 6'd18: r = 9'd218; 6'd19: r = 9'd230;
      6'd20: r = 9'd241; 6'd21: r = 9'd252; 6'd22: r = 9'd263; 6'd23: r = 9'd273;
      6'd24: r = 9'd284; 6'd25: r = 9'd294; 6'd26: r = 9'd304; 6'd27: r = 9'd314;
      6'd28: r = 9'd324; 6'd29: r = 9'd334; 6'd30: r = 9'd343; 6'd31: r = 9'd353;
      6'd32: r = 9'd362; 6'd33: r = 9'd370; 6'd34: r = 9'd379; 6'd35: r = 9'd387;
      6'd36: r = 9'd395; 6'd37: r = 9'd403; 6'd38: r = 9'd411; 6'd39: r = 9'd418;
      6'd40: r = 9'd425; 6'd41: r = 9'd432; 6'd42: r = 9'd439; 6'd43: r = 9'd445;
      6'd44: r = 9'd451; 6'd45: r = 9'd457; 6'd46: r = 9'd462; 6'd47: r = 9'd468;
      6'd48: r = 9'd473; 6'd49: r = 9'd477; 6'd50: r = 9'd482; 6'd51: r = 9'd486;
      6'd52: r = 9'd489; 6'd53: r = 9'd493; 6'd54: r = 9'd496; 6'd55: r = 9'd499;
      6'd56: r = 9'd502; 6'd57: r = 9'd504; 6'd58: r = 9'd506; 6'd59: r = 9'd508;
      6'd60: r = 9'd509; 6'd61: r = 9'd510; 6'd62: r = 9'd511; 6'd63: r = 9'd511;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [9:0] abs_sample;
  logic [5:0] trial;
  logic [8:0] rom_trial;
  logic       keep;
  logic [5:0] k_next;
  logic       fold;

  assign abs_sample = sample[9] ? (~sample + 10'd1) : sample;
  assign trial      = k_q | (6'd1 << bit_q);
  assign rom_trial  = rom_lookup(trial);
  assign keep       = (rom_trial <= mag_q);
  assign k_next     = keep ? trial : k_q;
  // Quadrants 1 and 3 (sign equal to slope) read the table mirrored.
  assign fold       = (sign_q == slope_q);

`ifdef SINE_PHASE_RESIDUAL_EN
  // ROM[k_q] is tracked in a register so the residual needs no second read.
  logic [8:0] romk_q, romk_d;
  logic [8:0] rom_sel;
  logic [3:0] resid_q, resid_d;
  assign rom_sel = keep ? rom_trial : romk_q;
`endif

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    slope_d = slope_q;
    k_d     = k_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = done_q;
    phase_d = phase_q;
`ifdef SINE_PHASE_RESIDUAL_EN
    romk_d  = romk_q;
    resid_d = resid_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEARCH;
          // -512 has no positive counterpart; it saturates to 511.
          mag_d   = abs_sample[9] ? 9'h1FF : abs_sample[8:0];
          sign_d  = sample[9];
          slope_d = slope;
          k_d     = '0;
          bit_d   = 3'd5;
          busy_d  = 1'b1;
`ifdef SINE_PHASE_RESIDUAL_EN
          romk_d  = '0;
`endif
        end
      end
      S_SEARCH: begin
        k_d = k_next;
`ifdef SINE_PHASE_RESIDUAL_EN
        romk_d = rom_sel;
`endif
        if (bit_q == 3'd0) begin
          // The result is written on the last search step so that it is
          // valid in the same cycle as the done pulse.
          state_d = S_DONE;
          done_d  = 1'b1;
          phase_d = {sign_q, fold, fold ? ~k_next : k_next};
`ifdef SINE_PHASE_RESIDUAL_EN
          resid_d = mag_q[3:0] - rom_sel[3:0];
`endif
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      slope_q <= 1'b0;
      k_q     <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= '0;
`ifdef SINE_PHASE_RESIDUAL_EN
      romk_q  <= '0;
      resid_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      slope_q <= slope_d;
      k_q     <= k_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      phase_q <= phase_d;
`ifdef SINE_PHASE_RESIDUAL_EN
      romk_q  <= romk_d;
      resid_q <= resid_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign phase_out = phase_q;
`ifdef SINE_PHASE_RESIDUAL_EN
  assign residual  = resid_q;
`endif

endmodule

// File: tb/tb_sine_phase_decoder.sv
// Testbench for sine_phase_decoder: table vectors, a model-driven sweep of
// every ROM entry, random samples, and hand-written control sequences.
module tb_sine_phase_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] sample;
  logic       slope;
  logic       busy;
  logic       done;
  logic [7:0] phase_out;
`ifdef SINE_PHASE_RESIDUAL_EN
  logic [3:0] residual;
`endif

  sine_phase_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sample    (sample),
    .slope     (slope),
    .busy      (busy),
    .done      (done),
    .phase_out (phase_out)
`ifdef SINE_PHASE_RESIDUAL_EN
    ,
    .residual  (residual)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] sample;
    logic       slope;
    logic [7:0] phase;
    logic [3:0] resid;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t exp_q[$];
  vec_t vecs[10];
  logic [7:0] last_phase;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int rom_m(input int k);
    real r;
    r = 512.0 * $sin(3.14159265358979323846 * k / 128.0);
    return int'($floor(r));
  endfunction

  function automatic vec_t model(input logic [9:0] s, input logic sl);
    vec_t r;
    int v, mag, k;
    logic neg;
    logic [5:0] kk;
    v   = int'($signed(s));
    neg = (v < 0);
    mag = neg ? -v : v;
    if (mag > 511) mag = 511;
    k = 0;
    for (int j = 0; j < 64; j++)
      if (rom_m(j) <= mag) k = j;
    kk = k[5:0];
    r.sample = s;
    r.slope  = sl;
    case ({neg, sl})
      2'b01:   r.phase = {2'b00, kk};
      2'b00:   r.phase = {2'b01, ~kk};
      2'b10:   r.phase = {2'b10, kk};
      default: r.phase = {2'b11, ~kk};
    endcase
    r.resid = 4'(mag - rom_m(k));
    return r;
  endfunction

  // Drives one request and returns just after the accepting edge.
  task automatic accept(input vec_t e, input bit push);
    @(negedge clk);
    sample = e.sample;
    slope  = e.slope;
    start  = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    sample = 10'($urandom);
    slope  = 1'($urandom);
    check("busy_after_accept", busy, 1);
  endtask

  // Waits (bounded) for done, expecting it exp_lat edges from now, then
  // scores the popped expectation and checks the pulse ends.
  task automatic wait_done(input int exp_lat);
    int lat = 0;
    vec_t e;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("done_latency", lat, exp_lat);
    check("sb_nonempty", int'(exp_q.size() > 0), 1);
    if (lat != 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("phase_out", phase_out, e.phase);
      last_phase = e.phase;
`ifdef SINE_PHASE_RESIDUAL_EN
      check("residual", residual, e.resid);
`endif
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   cnt;
    vec_t e, e2;

    vecs[0] = '{10'h16A, 1'b1, 8'h20, 4'd0};
    vecs[1] = '{10'h16B, 1'b0, 8'h5F, 4'd1};
    vecs[2] = '{10'h338, 1'b0, 8'h90, 4'd5};
    vecs[3] = '{10'h200, 1'b1, 8'hC0, 4'd0};
    vecs[4] = '{10'h000, 1'b0, 8'h7F, 4'd0};
    vecs[5] = '{10'h000, 1'b1, 8'h00, 4'd0};
    vecs[6] = '{10'h1FF, 1'b1, 8'h3F, 4'd0};
    vecs[7] = '{10'h3F4, 1'b1, 8'hFE, 4'd0};
    vecs[8] = '{10'h00B, 1'b0, 8'h7F, 4'd11};
    vecs[9] = '{10'h0CF, 1'b0, 8'h6E, 4'd0};

    rst = 1'b1; start = 1'b0; sample = '0; slope = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_phase", phase_out, 0);
`ifdef SINE_PHASE_RESIDUAL_EN
    check("reset_residual", residual, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // ROM anchors in the bench model itself
    check("model_rom1", rom_m(1), 12);
    check("model_rom26", rom_m(26), 304);
    check("model_rom63", rom_m(63), 511);

    for (int i = 0; i < 10; i++) begin
      accept(vecs[i], 1'b1);
      wait_done(6);
    end

    // phase_out holds after done
    repeat (3) @(posedge clk);
    #1;
    check("phase_hold", phase_out, last_phase);

    // every ROM entry exactly, random sign and slope
    for (int k = 0; k < 64; k++) begin
      int v;
      logic [9:0] s;
      v = rom_m(k);
      if ($urandom_range(1, 0) == 1) v = -v;
      s = 10'(v);
      e = model(s, 1'($urandom));
      accept(e, 1'b1);
      wait_done(6);
    end

    for (int i = 0; i < 16; i++) begin
      e = model(10'($urandom), 1'($urandom));
      accept(e, 1'b1);
      wait_done(6);
    end

    // second start three edges into the search is ignored
    e = model(10'h16A, 1'b1);
    accept(e, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; sample = 10'h0C3; slope = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3);
    count_dones(10, cnt);
    check("ignored_start_no_extra_done", cnt, 0);

    // reset during the search aborts the request
    e = model(10'h0C3, 1'b1);
    accept(e, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_phase", phase_out, 0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(10, cnt);
    check("abort_no_done", cnt, 0);
    check("abort_phase_after", phase_out, 0);

    // start held high: next request accepted 8 edges after the first
    e  = model(10'h200, 1'b0);
    e2 = model(10'h0CF, 1'b1);
    @(negedge clk);
    start = 1'b1; sample = e.sample; slope = e.slope;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    sample = e2.sample; slope = e2.slope;
    exp_q.push_back(e2);
    wait_done(6);
    @(posedge clk);
    #1;
    check("b2b_accept_busy", busy, 1);
    start = 1'b0;
    wait_done(6);

    // reset and start on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; sample = 10'h16A; slope = 1'b1;
    @(posedge clk);
    #1;
    check("rst_start_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    count_dones(10, cnt);
    check("rst_start_no_done", cnt, 0);
    check("rst_start_busy_later", busy, 0);

    check("sb_empty_at_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
